// File: rtl/alu_ctrl_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq_pkg
// Shared definitions for the ALU instruction sequencer:
//   - ALU opcode constants driven on ALU_OPRN
//   - instruction opcode / R-type funct constants
//   - sequencer state encoding
//   - instruction field bit positions
//   - decode result structure produced by alu_ctrl_decode
// ---------------------------------------------------------------------------
package alu_ctrl_seq_pkg;

   // ALU operation codes
   localparam logic [5:0] ALU_NOP = 6'd0;
   localparam logic [5:0] ALU_ADD = 6'd1;
   localparam logic [5:0] ALU_SUB = 6'd2;
   localparam logic [5:0] ALU_MUL = 6'd3;
   localparam logic [5:0] ALU_SRL = 6'd4;
   localparam logic [5:0] ALU_SLL = 6'd5;
   localparam logic [5:0] ALU_AND = 6'd6;
   localparam logic [5:0] ALU_OR  = 6'd7;
   localparam logic [5:0] ALU_NOR = 6'd8;
   localparam logic [5:0] ALU_SLT = 6'd9;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_MULI  = 6'h1D;

   // R-type funct codes
   localparam logic [5:0] F_SLL = 6'h01;
   localparam logic [5:0] F_SRL = 6'h02;
   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_NOR = 6'h27;
   localparam logic [5:0] F_SLT = 6'h2A;
   localparam logic [5:0] F_MUL = 6'h2C;

   // Instruction field positions
   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int SH_HI  = 10;
   localparam int SH_LO  = 6;
   localparam int FN_HI  = 5;
   localparam int FN_LO  = 0;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   // lui is executed as (zext imm) << 16 on the ALU
   localparam int LUI_SHIFT = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXE    = 2'd2,
      ST_WB     = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      OP2_RT    = 2'd0,
      OP2_SHAMT = 2'd1,
      OP2_IMM   = 2'd2,
      OP2_C16   = 2'd3
   } op2_sel_e;

   typedef enum logic {
      EXT_SIGN = 1'b0,
      EXT_ZERO = 1'b1
   } ext_e;

   typedef enum logic [1:0] {
      WD_NONE = 2'd0,
      WD_RD   = 2'd1,
      WD_RT   = 2'd2
   } wdest_e;

   typedef struct packed {
      logic [5:0] oprn;
      logic       op1_imm;    // operand 1 is the zero-extended immediate (lui)
      op2_sel_e   op2_sel;
      ext_e       ext;
      wdest_e     wdest;
      logic       is_branch;
      logic       br_ne;      // bne: taken when the difference is non-zero
      logic       is_mul;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ---------------------------------------------------------------------------
// alu_ctrl_decode
// Combinational instruction decoder for alu_ctrl_seq.
// Ports:
//   opcode  in   6  INSTR[31:26]
//   funct   in   6  INSTR[5:0]
//   dec     out  dec_t  ALU opcode, operand selects, immediate extension,
//                       write destination, branch/multiply/illegal flags
// ---------------------------------------------------------------------------
module alu_ctrl_decode
   import alu_ctrl_seq_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output dec_t       dec
);

   always_comb begin
      dec           = '0;
      dec.op2_sel   = OP2_RT;
      dec.ext       = EXT_SIGN;
      dec.wdest     = WD_NONE;
      case (opcode)
         OP_RTYPE: begin
            dec.wdest = WD_RD;
            case (funct)
               F_ADD: dec.oprn = ALU_ADD;
               F_SUB: dec.oprn = ALU_SUB;
               F_MUL: begin
                  dec.oprn   = ALU_MUL;
                  dec.is_mul = 1'b1;
               end
               F_AND: dec.oprn = ALU_AND;
               F_OR:  dec.oprn = ALU_OR;
               F_NOR: dec.oprn = ALU_NOR;
               F_SLT: dec.oprn = ALU_SLT;
               F_SRL: begin
                  dec.oprn    = ALU_SRL;
                  dec.op2_sel = OP2_SHAMT;
               end
               F_SLL: begin
                  dec.oprn    = ALU_SLL;
                  dec.op2_sel = OP2_SHAMT;
               end
               default: begin
                  dec.illegal = 1'b1;
                  dec.wdest   = WD_NONE;
               end
            endcase
         end
         OP_ADDI: begin
            dec.oprn    = ALU_ADD;
            dec.op2_sel = OP2_IMM;
            dec.wdest   = WD_RT;
         end
         OP_MULI: begin
            dec.oprn    = ALU_MUL;
            dec.op2_sel = OP2_IMM;
            dec.wdest   = WD_RT;
            dec.is_mul  = 1'b1;
         end
         OP_SLTI: begin
            dec.oprn    = ALU_SLT;
            dec.op2_sel = OP2_IMM;
            dec.wdest   = WD_RT;
         end
         OP_ANDI: begin
            dec.oprn    = ALU_AND;
            dec.op2_sel = OP2_IMM;
            dec.ext     = EXT_ZERO;
            dec.wdest   = WD_RT;
         end
         OP_ORI: begin
            dec.oprn    = ALU_OR;
            dec.op2_sel = OP2_IMM;
            dec.ext     = EXT_ZERO;
            dec.wdest   = WD_RT;
         end
         OP_LUI: begin
            dec.oprn    = ALU_SLL;
            dec.op1_imm = 1'b1;
            dec.op2_sel = OP2_C16;
            dec.wdest   = WD_RT;
         end
         OP_BEQ: begin
            dec.oprn      = ALU_SUB;
            dec.is_branch = 1'b1;
         end
         OP_BNE: begin
            dec.oprn      = ALU_SUB;
            dec.is_branch = 1'b1;
            dec.br_ne     = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
// Multi-cycle instruction sequencer driving an external 32-bit ALU and
// register file. One instruction at a time: IDLE -> DECODE -> EXE -> WB.
// Optional macro ALU_CTRL_SEQ_MUL_WAIT_EN: mul/muli hold EXE for 1+MUL_WAIT
// cycles so a deep multiplier can settle.
// Ports:
//   CLK, RST                    clock (rising), async active-low reset
//   INSTR_VALID/READY, INSTR,   instruction handshake, word and its PC
//   PC_IN
//   RF_READ, RF_ADDR_R1/R2,     register-file read (data one cycle later)
//   RF_DATA_R1/R2
//   RF_WRITE, RF_ADDR_W,        register-file write-back
//   RF_DATA_W
//   ALU_OP1/OP2/OPRN, ALU_OUT,  ALU operands, opcode and result
//   ALU_ZERO
//   BR_TAKEN, BR_TARGET         branch resolution pulse and target
//   DONE, ILLEGAL               retire pulse and decode-failure flag
// ---------------------------------------------------------------------------
module alu_ctrl_seq
   import alu_ctrl_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5,
   parameter int MUL_WAIT   = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  INSTR_VALID,
   output logic                  INSTR_READY,
   input  logic [31:0]           INSTR,
   input  logic [31:0]           PC_IN,
   output logic                  RF_READ,
   output logic [REG_ADDR_W-1:0] RF_ADDR_R1,
   output logic [REG_ADDR_W-1:0] RF_ADDR_R2,
   input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
   input  logic [DATA_WIDTH-1:0] RF_DATA_R2,
   output logic                  RF_WRITE,
   output logic [REG_ADDR_W-1:0] RF_ADDR_W,
   output logic [DATA_WIDTH-1:0] RF_DATA_W,
   output logic [DATA_WIDTH-1:0] ALU_OP1,
   output logic [DATA_WIDTH-1:0] ALU_OP2,
   output logic [5:0]            ALU_OPRN,
   input  logic [DATA_WIDTH-1:0] ALU_OUT,
   input  logic                  ALU_ZERO,
   output logic                  BR_TAKEN,
   output logic [31:0]           BR_TARGET,
   output logic                  DONE,
   output logic                  ILLEGAL
);

   state_e                state_q, state_d;
   logic                  rdy_q, rdy_d;
   logic [31:0]           instr_q, instr_d;
   logic [31:0]           pc_q, pc_d;
   logic [DATA_WIDTH-1:0] op1_q, op1_d;
   logic [DATA_WIDTH-1:0] op2_q, op2_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic                  zero_q, zero_d;
   logic                  exe_first_q, exe_first_d;

   dec_t                  dec;
   logic                  exe_last;

   logic [15:0]           imm;
   logic [DATA_WIDTH-1:0] imm_ext;
   logic [DATA_WIDTH-1:0] imm_zext;
   logic [DATA_WIDTH-1:0] op1_sel;
   logic [DATA_WIDTH-1:0] op2_sel;
   logic [REG_ADDR_W-1:0] waddr;
   logic                  wr_en;
   logic                  br_hit;
   logic signed [31:0]    br_target_s;

   alu_ctrl_decode u_decode (
      .opcode (instr_q[OPC_HI:OPC_LO]),
      .funct  (instr_q[FN_HI:FN_LO]),
      .dec    (dec)
   );

   assign imm      = instr_q[IMM_HI:IMM_LO];
   assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, imm};
   assign imm_ext  = (dec.ext == EXT_ZERO) ? imm_zext
                                           : {{(DATA_WIDTH-16){imm[15]}}, imm};

   assign op1_sel = dec.op1_imm ? imm_zext : RF_DATA_R1;

   always_comb begin
      op2_sel = RF_DATA_R2;
      case (dec.op2_sel)
         OP2_RT:    op2_sel = RF_DATA_R2;
         OP2_SHAMT: op2_sel = DATA_WIDTH'(instr_q[SH_HI:SH_LO]);
         OP2_IMM:   op2_sel = imm_ext;
         OP2_C16:   op2_sel = DATA_WIDTH'(LUI_SHIFT);
         default:   op2_sel = RF_DATA_R2;
      endcase
   end

   assign waddr  = (dec.wdest == WD_RD) ? REG_ADDR_W'(instr_q[RD_HI:RD_LO])
                                        : REG_ADDR_W'(instr_q[RT_HI:RT_LO]);
   // r0 is hardwired; writes to it are dropped but the instruction still retires
   assign wr_en  = (dec.wdest != WD_NONE) && (waddr != '0);
   assign br_hit = dec.is_branch && (dec.br_ne ? !zero_q : zero_q);

   // Dedicated target adder, independent of the ALU
   assign br_target_s = $signed(pc_q) + 32'sd1 + $signed({{16{imm[15]}}, imm});

`ifdef ALU_CTRL_SEQ_MUL_WAIT_EN
   localparam int WAIT_W = (MUL_WAIT > 0) ? $clog2(MUL_WAIT + 1) : 1;

   logic [WAIT_W-1:0] wait_q, wait_d;

   assign exe_last = (wait_q == '0);

   always_comb begin
      wait_d = wait_q;
      if (state_q == ST_DECODE) begin
         wait_d = dec.is_mul ? WAIT_W'(MUL_WAIT) : '0;
      end else if ((state_q == ST_EXE) && !exe_last) begin
         wait_d = wait_q - 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   // Single-cycle EXE for every operation
   logic unused_mul_cfg;
   assign unused_mul_cfg = ^{dec.is_mul, MUL_WAIT};
   assign exe_last       = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      rdy_d       = 1'b1;
      instr_d     = instr_q;
      pc_d        = pc_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      res_d       = res_q;
      zero_d      = zero_q;
      exe_first_d = 1'b0;

      INSTR_READY = 1'b0;
      RF_READ     = 1'b0;
      RF_ADDR_R1  = '0;
      RF_ADDR_R2  = '0;
      RF_WRITE    = 1'b0;
      RF_ADDR_W   = '0;
      RF_DATA_W   = '0;
      ALU_OP1     = op1_q;
      ALU_OP2     = op2_q;
      ALU_OPRN    = ALU_NOP;
      BR_TAKEN    = 1'b0;
      BR_TARGET   = '0;
      DONE        = 1'b0;
      ILLEGAL     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // rdy_q keeps READY low until the first clock after reset release
            INSTR_READY = rdy_q;
            if (INSTR_VALID && rdy_q) begin
               instr_d = INSTR;
               pc_d    = PC_IN;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            RF_READ    = 1'b1;
            RF_ADDR_R1 = REG_ADDR_W'(instr_q[RS_HI:RS_LO]);
            RF_ADDR_R2 = REG_ADDR_W'(instr_q[RT_HI:RT_LO]);
            if (dec.illegal) begin
               state_d = ST_WB;
            end else begin
               state_d     = ST_EXE;
               exe_first_d = 1'b1;
            end
         end
         ST_EXE: begin
            ALU_OPRN = dec.oprn;
            // Register-file data arrives this cycle; capture it so the
            // operands stay stable for any further EXE cycles and afterwards.
            if (exe_first_q) begin
               op1_d   = op1_sel;
               op2_d   = op2_sel;
               ALU_OP1 = op1_sel;
               ALU_OP2 = op2_sel;
            end
            if (exe_last) begin
               res_d   = ALU_OUT;
               zero_d  = ALU_ZERO;
               state_d = ST_WB;
            end
         end
         ST_WB: begin
            DONE    = 1'b1;
            ILLEGAL = dec.illegal;
            if (!dec.illegal) begin
               if (wr_en) begin
                  RF_WRITE  = 1'b1;
                  RF_ADDR_W = waddr;
                  RF_DATA_W = res_q;
               end
               if (br_hit) begin
                  BR_TAKEN  = 1'b1;
                  BR_TARGET = br_target_s;
               end
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         rdy_q       <= 1'b0;
         instr_q     <= '0;
         pc_q        <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         res_q       <= '0;
         zero_q      <= 1'b0;
         exe_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= rdy_d;
         instr_q     <= instr_d;
         pc_q        <= pc_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         res_q       <= res_d;
         zero_q      <= zero_d;
         exe_first_q <= exe_first_d;
      end
   end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Multi-cycle instruction sequencer that sits on the opposite side of the 32-bit ALU interface.
- Accepts one instruction at a time and reads source registers from the register file.
- Drives the ALU operands and opcode, samples the ALU result and zero flag, then writes back or resolves a branch.
- Sits between instruction fetch and the register file / ALU datapath.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_W, 5, register-file address width.
- MUL_WAIT, 2, extra EXE cycles held for multiply (used only with the optional feature).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- INSTR_VALID  input  1  instruction offered.
- INSTR_READY  output  1  sequencer can accept.
- INSTR  input  32  instruction word.
- PC_IN  input  32  word address of INSTR.
- RF_READ  output  1  register-file read strobe.
- RF_ADDR_R1  output  REG_ADDR_W  rs.
- RF_ADDR_R2  output  REG_ADDR_W  rt.
- RF_DATA_R1  input  DATA_WIDTH  rs data, valid one cycle after RF_READ.
- RF_DATA_R2  input  DATA_WIDTH  rt data, valid one cycle after RF_READ.
- RF_WRITE  output  1  write strobe.
- RF_ADDR_W  output  REG_ADDR_W  destination.
- RF_DATA_W  output  DATA_WIDTH  write data.
- ALU_OP1  output  DATA_WIDTH  ALU operand 1.
- ALU_OP2  output  DATA_WIDTH  ALU operand 2.
- ALU_OPRN  output  6  ALU opcode.
- ALU_OUT  input  DATA_WIDTH  ALU result.
- ALU_ZERO  input  1  ALU result is zero.
- BR_TAKEN  output  1  branch taken, one-cycle pulse.
- BR_TARGET  output  32  branch target.
- DONE  output  1  instruction retired, one-cycle pulse.
- ILLEGAL  output  1  decode failure, one-cycle pulse with DONE.

Behaviour:
- Reset:
  - CLK rising edge; RST asynchronous active-low.
  - While RST=0, the state is IDLE and every output is 0, including INSTR_READY.
  - INSTR_READY rises on the first clock after RST deasserts.
  - Reset mid-instruction aborts it: no RF_WRITE, no BR_TAKEN, no DONE.
- States: IDLE -> DECODE -> EXE -> WB -> IDLE.
  - IDLE: INSTR_READY=1. On INSTR_VALID&INSTR_READY, latch INSTR and PC_IN, go to DECODE. INSTR_READY=0 in all other states.
  - DECODE: RF_READ=1, RF_ADDR_R1=INSTR[25:21], RF_ADDR_R2=INSTR[20:16]. An unsupported opcode/funct goes to WB with the illegal flag set.
  - EXE: drive ALU_OP1/OP2/OPRN from registered values; hold for one cycle; latch ALU_OUT and ALU_ZERO at the end of the cycle.
  - WB: DONE=1 for one cycle.
    - R-type: RF_WRITE to rd=INSTR[15:11].
    - I-type ALU: RF_WRITE to rt.
    - Branch: BR_TAKEN per the branch rules.
- Latency: 4 cycles from accept to DONE; throughput 1 instruction per 4 cycles.
- ALU opcodes: 1 add, 2 sub, 3 mul (low word), 4 shift right, 5 shift left, 6 and, 7 or, 8 nor, 9 slt.
- R-type (opcode 0x00), funct -> OPRN:
  - 0x20 add -> 1; 0x22 sub -> 2; 0x2C mul -> 3.
  - 0x24 and -> 6; 0x25 or -> 7; 0x27 nor -> 8; 0x2A slt -> 9.
  - 0x02 srl -> 4; 0x01 sll -> 5.
  - Shifts: OP1=R[rs], OP2=zero-extended shamt INSTR[10:6].
  - All other R-type: OP1=R[rs], OP2=R[rt].
- I-type:
  - Sign-extended imm16: addi 0x08 (1), muli 0x1D (3), slti 0x0A (9).
  - Zero-extended imm16: andi 0x0C (6), ori 0x0D (7).
  - lui 0x0F: OP1=zero-extended imm, OP2=16, OPRN=5.
- Branches:
  - beq 0x04 and bne 0x05 use OPRN=2 with R[rs], R[rt].
  - beq is taken if ALU_ZERO=1; bne is taken if ALU_ZERO=0.
  - BR_TARGET = PC_IN + 1 + sext(imm16), computed by an internal adder, not the ALU; valid whenever BR_TAKEN=1.
- Writes with destination register 0 are suppressed (RF_WRITE stays 0); DONE still pulses.
- Illegal instruction: WB with DONE=1 and ILLEGAL=1; no write, no branch.
- Outside EXE, ALU_OPRN=0 and the operands hold their last values.
- INSTR_VALID while busy is ignored; the instruction is not consumed until INSTR_READY=1.

Optional Feature:
- Macro: ALU_CTRL_SEQ_MUL_WAIT_EN.
- Defined: mul and muli hold EXE for 1+MUL_WAIT cycles with operands stable, giving the deep multiplier time to settle; ALU_OUT is latched on the last EXE cycle.
  - Multiply latency becomes 4+MUL_WAIT cycles.
  - Uses an internal down-counter, cleared on reset.
- Undefined: every operation takes 1 EXE cycle and MUL_WAIT is unused.

Decomposition:
- Shared package holds:
  - ALU opcode constants (ADD..SLT);
  - opcode/funct constants;
  - the state encoding;
  - instruction field index constants.
- Sub-module alu_ctrl_decode: combinational INSTR -> {OPRN, operand-select, immediate-extend mode, write-dest select, is_branch, illegal}.

Test Plan:
- add: R1=5, R2=7, INSTR 0x00221820 (add r3,r1,r2) -> ALU_OPRN=1 in EXE; RF_WRITE r3=12 in WB; DONE 4 cycles after accept.
- addi r4,r0,0xFFFF -> OP2=0xFFFFFFFF; write r4=0xFFFFFFFF. Then lui r5,0x1234 -> OPRN=5, OP2=16, write r5=0x12340000.
- beq r1,r1,-2 at PC_IN=0x10: ALU_ZERO=1 -> BR_TAKEN=1, BR_TARGET=0x0F, no RF_WRITE. bne with the same operands -> BR_TAKEN=0.
- Write to r0 (add r0,r1,r2) -> RF_WRITE=0, DONE=1. Opcode 0x3F -> ILLEGAL=1, DONE=1, no write.
- RST low during EXE -> all outputs 0 immediately; no DONE; INSTR_READY=1 on the first clock after release.
- Optional feature defined with MUL_WAIT=2: mul of 3 and 4 -> EXE held 3 cycles; write 12; DONE at cycle 6. Feature undefined -> DONE at cycle 4.
